// File: rtl/vga_frame_reader_if.sv
// Read-port bundle between vga_frame_reader and a synchronous data RAM.
//   rd_addr : word address, master -> RAM
//   rd_en   : one-clk read strobe, master -> RAM
//   rd_data : read data, valid exactly one clk after rd_en, RAM -> master
interface vga_frame_reader_if #(
  parameter int S = 32
);
  logic [S-1:0] rd_addr;
  logic         rd_en;
  logic [S-1:0] rd_data;

  modport master (output rd_addr, output rd_en, input rd_data);
  modport slave  (input rd_addr, input rd_en, output rd_data);
endinterface

// File: rtl/vga_frame_reader.sv
// VGA frame reader: generates 640x480@60 timing from a 50 MHz clock and,
// while enabled, streams an IMG_W x IMG_H image out of a data RAM, one word
// per pixel, placing it in the top-left corner of the visible area.
// Ports:
//   clk         : 50 MHz system clock
//   rst         : asynchronous active-low reset
//   enable      : display request, sampled only at the frame boundary
//   rd          : RAM read port (rd_addr / rd_en out, rd_data in)
//   rgb         : pixel colour {R,G,B}, one pixel behind the counters
//   h_sync      : horizontal sync, active-low, aligned with rgb
//   v_sync      : vertical sync, active-low, aligned with rgb
//   vga_clk     : 25 MHz pixel clock (clk / 2)
//   frame_start : one-clk pulse on the tick where the counters wrap to (0,0)
// The H_* / V_* parameters default to standard 640x480@60 timing.
module vga_frame_reader #(
  parameter int           S         = 32,
  parameter logic [S-1:0] BASE_ADDR = '0,
  parameter int           IMG_W     = 100,
  parameter int           IMG_H     = 100,
  parameter int           H_VIS     = 640,
  parameter int           H_FP      = 16,
  parameter int           H_SYNC    = 96,
  parameter int           H_BP      = 48,
  parameter int           V_VIS     = 480,
  parameter int           V_FP      = 10,
  parameter int           V_SYNC    = 2,
  parameter int           V_BP      = 33
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enable,
  vga_frame_reader_if.master rd,
  output logic [23:0]        rgb,
  output logic               h_sync,
  output logic               v_sync,
  output logic               vga_clk,
  output logic               frame_start
);
  localparam int H_TOT = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_VIS + V_FP + V_SYNC + V_BP;
  localparam logic [9:0] H_LAST   = 10'(H_TOT - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOT - 1);
  localparam logic [9:0] HS_FIRST = 10'(H_VIS + H_FP);
  localparam logic [9:0] HS_LAST  = 10'(H_VIS + H_FP + H_SYNC - 1);
  localparam logic [9:0] VS_FIRST = 10'(V_VIS + V_FP);
  localparam logic [9:0] VS_LAST  = 10'(V_VIS + V_FP + V_SYNC - 1);
  localparam logic [9:0] IMG_W_C  = 10'(IMG_W);
  localparam logic [9:0] IMG_H_C  = 10'(IMG_H);
  localparam logic [S-1:0] ROW_STEP = S'(IMG_W);

  typedef enum logic {IDLE = 1'b0, SHOW = 1'b1} state_e;

  state_e       state_q, state_d;
  logic         tick_q;
  logic [9:0]   h_cnt_q, h_cnt_d;
  logic [9:0]   v_cnt_q, v_cnt_d;
  logic [S-1:0] row_base_q, row_base_d;
  logic         line_end, frame_end, in_img;
  logic         vld_p0_q, hs_p0_q, vs_p0_q;
  logic [23:0]  rgb_q;
  logic         hs_q, vs_q;
  logic         unused_rd_data;

  // Upper colour-word bits carry no pixel information.
  assign unused_rd_data = ^rd.rd_data[S-1:24];

  // tick_q is high in every second clk; it doubles as the pixel clock so
  // vga_clk rises in exactly the cycle where the pixel tick is asserted.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) tick_q <= 1'b0;
    else      tick_q <= ~tick_q;
  end

  assign line_end  = tick_q && (h_cnt_q == H_LAST);
  assign frame_end = line_end && (v_cnt_q == V_LAST);

  // h_cnt doubles as the column offset inside the current row; the row base
  // steps by IMG_W per image line so no multiplier is needed.
  always_comb begin
    h_cnt_d    = h_cnt_q;
    v_cnt_d    = v_cnt_q;
    row_base_d = row_base_q;
    if (tick_q) begin
      if (line_end) begin
        h_cnt_d = '0;
        if (frame_end) begin
          v_cnt_d    = '0;
          row_base_d = BASE_ADDR;
        end else begin
          v_cnt_d = v_cnt_q + 10'd1;
          if (v_cnt_q < IMG_H_C) row_base_d = row_base_q + ROW_STEP;
        end
      end else begin
        h_cnt_d = h_cnt_q + 10'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      h_cnt_q    <= '0;
      v_cnt_q    <= '0;
      row_base_q <= BASE_ADDR;
    end else begin
      h_cnt_q    <= h_cnt_d;
      v_cnt_q    <= v_cnt_d;
      row_base_q <= row_base_d;
    end
  end

  // FSM: state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // FSM: next state, only decided at the frame boundary
  always_comb begin
    state_d = state_q;
    if (frame_end) state_d = enable ? SHOW : IDLE;
  end

  // FSM: outputs (read strobe for in-image pixels while showing)
  always_comb begin
    in_img     = tick_q && (state_q == SHOW) &&
                 (h_cnt_q < IMG_W_C) && (v_cnt_q < IMG_H_C);
    rd.rd_en   = in_img;
    rd.rd_addr = in_img ? (row_base_q + {{(S-10){1'b0}}, h_cnt_q}) : '0;
  end

  assign frame_start = frame_end;

  // Stage p0: capture pixel attributes on the tick, while the read is in flight
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_p0_q <= 1'b0;
      hs_p0_q  <= 1'b1;
      vs_p0_q  <= 1'b1;
    end else if (tick_q) begin
      vld_p0_q <= in_img;
      hs_p0_q  <= !((h_cnt_q >= HS_FIRST) && (h_cnt_q <= HS_LAST));
      vs_p0_q  <= !((v_cnt_q >= VS_FIRST) && (v_cnt_q <= VS_LAST));
    end
  end

  // Stage p1: RAM data has arrived; colour and syncs are updated together
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rgb_q <= '0;
      hs_q  <= 1'b1;
      vs_q  <= 1'b1;
    end else if (!tick_q) begin
      rgb_q <= vld_p0_q ? rd.rd_data[23:0] : 24'h000000;
      hs_q  <= hs_p0_q;
      vs_q  <= vs_p0_q;
    end
  end

  assign rgb     = rgb_q;
  assign h_sync  = hs_q;
  assign v_sync  = vs_q;
  assign vga_clk = tick_q;
endmodule
